id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// count of stall bubbles. Flush squashes the decode instruction ahead of stall.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        IFID_Rs,
    input  logic [4:0]        IFID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExt,
    input  logic              ID_RegDst,
    input  logic              ID_ALUSrc,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_RegWrite,
    input  logic [2:0]        ID_ALUOp,
    input  logic              Flush,
    output logic [4:0]        IDEXRs,
    output logic [4:0]        IDEXRt,
    output logic [4:0]        IDEXRd,
    output logic [DATA_W-1:0] IDEX_ReadData1,
    output logic [DATA_W-1:0] IDEX_ReadData2,
    output logic [DATA_W-1:0] IDEX_SignExt,
    output logic              IDEX_RegDst,
    output logic              IDEX_ALUSrc,
    output logic              IDEX_MemRead,
    output logic              IDEX_MemWrite,
    output logic              IDEX_MemtoReg,
    output logic              IDEX_RegWrite,
    output logic [2:0]        IDEX_ALUOp,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              Stall,
    output logic [CNT_W-1:0]  StallCount
);

    logic bubble;

    // $0 is never a real hazard source, so a load targeting it never stalls
    assign Stall     = IDEX_MemRead && (IDEXRt != 5'd0) &&
                       ((IDEXRt == IFID_Rs) || (IDEXRt == IFID_Rt));
    assign PCWrite   = Flush | ~Stall;
    assign IFIDWrite = Flush | ~Stall;
    assign bubble    = Stall | Flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IDEXRs         <= '0;
            IDEXRt         <= '0;
            IDEXRd         <= '0;
            IDEX_ReadData1 <= '0;
            IDEX_ReadData2 <= '0;
            IDEX_SignExt   <= '0;
            IDEX_RegDst    <= 1'b0;
            IDEX_ALUSrc    <= 1'b0;
            IDEX_MemRead   <= 1'b0;
            IDEX_MemWrite  <= 1'b0;
            IDEX_MemtoReg  <= 1'b0;
            IDEX_RegWrite  <= 1'b0;
            IDEX_ALUOp     <= '0;
            StallCount     <= '0;
        end else begin
            if (bubble) begin
                // register numbers cleared too so forwarding never matches a bubble
                IDEXRs         <= '0;
                IDEXRt         <= '0;
                IDEXRd         <= '0;
                IDEX_ReadData1 <= '0;
                IDEX_ReadData2 <= '0;
                IDEX_SignExt   <= '0;
                IDEX_RegDst    <= 1'b0;
                IDEX_ALUSrc    <= 1'b0;
                IDEX_MemRead   <= 1'b0;
                IDEX_MemWrite  <= 1'b0;
                IDEX_MemtoReg  <= 1'b0;
                IDEX_RegWrite  <= 1'b0;
                IDEX_ALUOp     <= '0;
            end else begin
                IDEXRs         <= IFID_Rs;
                IDEXRt         <= IFID_Rt;
                IDEXRd         <= ID_Rd;
                IDEX_ReadData1 <= ID_ReadData1;
                IDEX_ReadData2 <= ID_ReadData2;
                IDEX_SignExt   <= ID_SignExt;
                IDEX_RegDst    <= ID_RegDst;
                IDEX_ALUSrc    <= ID_ALUSrc;
                IDEX_MemRead   <= ID_MemRead;
                IDEX_MemWrite  <= ID_MemWrite;
                IDEX_MemtoReg  <= ID_MemtoReg;
                IDEX_RegWrite  <= ID_RegWrite;
                IDEX_ALUOp     <= ID_ALUOp;
            end
            // flush-induced bubbles are not stalls
            if (Stall && !Flush && (StallCount != '1))
                StallCount <= StallCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a default instance and a CNT_W=2 instance
// share all inputs; expected register state is queued per edge and compared.
module tb_id_ex_stage;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, se;
        logic        regdst, alusrc, memread, memwrite, memtoreg, regwrite;
        logic [2:0]  aluop;
    } idex_t;

    typedef struct packed {
        idex_t       r;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  IFID_Rs = '0, IFID_Rt = '0, ID_Rd = '0;
    logic [31:0] ID_ReadData1 = '0, ID_ReadData2 = '0, ID_SignExt = '0;
    logic        ID_RegDst = 0, ID_ALUSrc = 0, ID_MemRead = 0, ID_MemWrite = 0;
    logic        ID_MemtoReg = 0, ID_RegWrite = 0, Flush = 0;
    logic [2:0]  ID_ALUOp = '0;

    logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
    logic [31:0] a_d1, a_d2, a_se, b_d1, b_d2, b_se;
    logic        a_regdst, a_alusrc, a_memread, a_memwrite, a_memtoreg, a_regwrite;
    logic        b_regdst, b_alusrc, b_memread, b_memwrite, b_memtoreg, b_regwrite;
    logic [2:0]  a_aluop, b_aluop;
    logic        a_pcw, a_ifw, a_stall, b_pcw, b_ifw, b_stall;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    idex_t obs_a, obs_b, cur_in;
    exp_t  m;
    exp_t  q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .ID_Rd(ID_Rd),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExt(ID_SignExt),
        .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg), .ID_RegWrite(ID_RegWrite),
        .ID_ALUOp(ID_ALUOp), .Flush(Flush),
        .IDEXRs(a_rs), .IDEXRt(a_rt), .IDEXRd(a_rd),
        .IDEX_ReadData1(a_d1), .IDEX_ReadData2(a_d2), .IDEX_SignExt(a_se),
        .IDEX_RegDst(a_regdst), .IDEX_ALUSrc(a_alusrc), .IDEX_MemRead(a_memread),
        .IDEX_MemWrite(a_memwrite), .IDEX_MemtoReg(a_memtoreg), .IDEX_RegWrite(a_regwrite),
        .IDEX_ALUOp(a_aluop), .PCWrite(a_pcw), .IFIDWrite(a_ifw), .Stall(a_stall),
        .StallCount(a_cnt)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .ID_Rd(ID_Rd),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExt(ID_SignExt),
        .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg), .ID_RegWrite(ID_RegWrite),
        .ID_ALUOp(ID_ALUOp), .Flush(Flush),
        .IDEXRs(b_rs), .IDEXRt(b_rt), .IDEXRd(b_rd),
        .IDEX_ReadData1(b_d1), .IDEX_ReadData2(b_d2), .IDEX_SignExt(b_se),
        .IDEX_RegDst(b_regdst), .IDEX_ALUSrc(b_alusrc), .IDEX_MemRead(b_memread),
        .IDEX_MemWrite(b_memwrite), .IDEX_MemtoReg(b_memtoreg), .IDEX_RegWrite(b_regwrite),
        .IDEX_ALUOp(b_aluop), .PCWrite(b_pcw), .IFIDWrite(b_ifw), .Stall(b_stall),
        .StallCount(b_cnt)
    );

    assign obs_a  = {a_rs, a_rt, a_rd, a_d1, a_d2, a_se, a_regdst, a_alusrc, a_memread,
                     a_memwrite, a_memtoreg, a_regwrite, a_aluop};
    assign obs_b  = {b_rs, b_rt, b_rd, b_d1, b_d2, b_se, b_regdst, b_alusrc, b_memread,
                     b_memwrite, b_memtoreg, b_regwrite, b_aluop};
    assign cur_in = {IFID_Rs, IFID_Rt, ID_Rd, ID_ReadData1, ID_ReadData2, ID_SignExt,
                     ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_MemtoReg,
                     ID_RegWrite, ID_ALUOp};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // state visible while reset is held, checked without any clock edge
    task automatic check_reset_state(input string tag);
        check({tag, "_idex"}, obs_a, '0);
        check({tag, "_idex_b"}, obs_b, '0);
        check({tag, "_cnt"}, a_cnt, 0);
        check({tag, "_cnt2"}, b_cnt, 0);
        check({tag, "_stall"}, {a_stall, b_stall}, 2'b00);
        check({tag, "_wr"}, {a_pcw, a_ifw, b_pcw, b_ifw}, 4'b1111);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        IFID_Rs = 5'($urandom); IFID_Rt = 5'($urandom); ID_MemRead = 1'($urandom);
        reset = 1'b1;
        #1;
        check_reset_state("rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_edge");
        @(negedge clk);
        reset = 1'b0;
        m = '0;
        q.delete();
    endtask

    task automatic set_inputs(input logic [4:0] rs, rt, rd, input logic mr, fl);
        IFID_Rs = rs; IFID_Rt = rt; ID_Rd = rd;
        ID_ReadData1 = $urandom; ID_ReadData2 = $urandom; ID_SignExt = $urandom;
        ID_RegDst = 1'($urandom); ID_ALUSrc = 1'($urandom); ID_MemWrite = 1'($urandom);
        ID_MemtoReg = 1'($urandom); ID_RegWrite = 1'($urandom); ID_ALUOp = 3'($urandom);
        ID_MemRead = mr; Flush = fl;
    endtask

    // one decode cycle: check combinational hazard outputs, queue the expected
    // register state for the coming edge, then compare after the edge
    task automatic drive(input logic [4:0] rs, rt, rd, input logic mr, fl, input logic hold = 1'b0);
        exp_t nx;
        logic st;
        @(negedge clk);
        if (!hold) set_inputs(rs, rt, rd, mr, fl);
        else Flush = fl;
        #1;
        st = m.r.memread && (m.r.rt != 5'd0) && (m.r.rt == IFID_Rs || m.r.rt == IFID_Rt);
        check("stall", {a_stall, b_stall}, {st, st});
        check("pcwrite", {a_pcw, b_pcw}, {2{Flush | ~st}});
        check("ifidwrite", {a_ifw, b_ifw}, {2{Flush | ~st}});
        nx.r    = (st || Flush) ? '0 : cur_in;
        nx.cnt  = (st && !Flush && m.cnt  != 16'hffff) ? m.cnt + 16'd1 : m.cnt;
        nx.cnt2 = (st && !Flush && m.cnt2 != 2'b11)    ? m.cnt2 + 2'd1 : m.cnt2;
        q.push_back(nx);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            nx = q.pop_front();
            check("idex", obs_a, nx.r);
            check("idex_b", obs_b, nx.r);
            check("cnt", a_cnt, nx.cnt);
            check("cnt2", b_cnt, nx.cnt2);
            m = nx;
        end
    endtask

    initial begin
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};
        m = '0;

        apply_reset();

        // load-use: lw $8 then consumer of $8, held for one stall, then captured
        drive(5'd2, 5'd8, 5'd0, 1'b1, 1'b0);
        drive(5'd8, 5'd3, 5'd9, 1'b0, 1'b0);
        check("lu_bubble_ctrl", {a_memread, a_regwrite, a_aluop, a_rs, a_rt, a_rd}, '0);
        check("lu_cnt1", a_cnt, 1);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("lu_capture_rs", a_rs, 8);
        check("lu_no_stall", a_stall, 0);

        // load to $0 never stalls
        drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        check("rt0_cnt", a_cnt, 1);

        // hazard coinciding with flush: one bubble, not counted
        drive(5'd1, 5'd9, 5'd0, 1'b1, 1'b0);
        drive(5'd9, 5'd9, 5'd7, 1'b0, 1'b1);
        check("flush_cnt", a_cnt, 1);

        // back-to-back loads, each hazarding on the previous
        drive(5'd1, 5'd5, 5'd0, 1'b1, 1'b0);
        drive(5'd5, 5'd6, 5'd0, 1'b1, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(5'd6, 5'd2, 5'd3, 1'b0, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("b2b_cnt", a_cnt, 3);

        // saturation of the 2-bit counter
        apply_reset();
        for (int unsigned k = 0; k < 5; k++) begin
            drive(5'd0, 5'(k + 10), 5'd1, 1'b1, 1'b0);
            drive(5'(k + 10), 5'd0, 5'd2, 1'b0, 1'b0);
            check("sat_seq", b_cnt, sat_exp[k]);
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        end
        check("sat_wide_cnt", a_cnt, 5);

        // asynchronous reset while a stall is being asserted
        drive(5'd3, 5'd7, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        set_inputs(5'd7, 5'd1, 5'd2, 1'b0, 1'b0);
        #1;
        check("pre_rst_stall", a_stall, 1);
        reset = 1'b1;
        #1;
        check_reset_state("mid_stall_rst");
        @(negedge clk);
        reset = 1'b0;
        m = '0;
        q.delete();
        drive(5'd7, 5'd1, 5'd2, 1'b0, 1'b0);
        check("post_rst_capture_rs", a_rs, 7);

        // random traffic over a small register range to provoke hazards
        for (int unsigned i = 0; i < 200; i++)
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                  1'($urandom), ($urandom_range(0, 7) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
